// File: rtl/bp_cce_gad_seq.sv
// bp_cce_gad_seq: sequential GAD that folds directory read beats into coherence decision flags.
// Coherence state bits: [0]=shared, [1]=dirty, [2]=owned (e.g. S=001, E=100, M=110, O=111).
module bp_cce_gad_seq #(
  parameter int num_lce_p = 8,
  parameter int lce_assoc_p = 8,
  parameter int lce_per_beat_p = 2,
  parameter int moesi_p = 0,
  localparam int lg_num_lce_lp = (num_lce_p > 1) ? $clog2(num_lce_p) : 1,
  localparam int lg_lce_assoc_lp = (lce_assoc_p > 1) ? $clog2(lce_assoc_p) : 1,
  localparam int bp_cce_coh_bits = 3
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic gad_v_i,
  output logic gad_ready_o,
  input  logic [lg_num_lce_lp-1:0] req_lce_i,
  input  logic req_type_flag_i,
  input  logic lru_dirty_flag_i,
  input  logic lru_cached_excl_flag_i,
  input  logic beat_v_i,
  input  logic [lce_per_beat_p-1:0] beat_hits_i,
  input  logic [lce_per_beat_p-1:0][lg_lce_assoc_lp-1:0] beat_ways_i,
  input  logic [lce_per_beat_p-1:0][bp_cce_coh_bits-1:0] beat_coh_states_i,
  output logic v_o,
  input  logic yumi_i,
  output logic [lg_lce_assoc_lp-1:0] req_addr_way_o,
  output logic [lg_num_lce_lp-1:0] transfer_lce_o,
  output logic [lg_lce_assoc_lp-1:0] transfer_way_o,
  output logic transfer_flag_o,
  output logic replacement_flag_o,
  output logic upgrade_flag_o,
  output logic invalidate_flag_o,
  output logic downgrade_flag_o,
  output logic cached_flag_o,
  output logic cached_exclusive_flag_o,
  output logic cached_owned_flag_o,
  output logic cached_dirty_flag_o
);
  localparam int num_beats_lp = (num_lce_p + lce_per_beat_p - 1) / lce_per_beat_p;
  localparam int lg_beats_lp = (num_beats_lp > 1) ? $clog2(num_beats_lp) : 1;
  localparam int shared_bit = 0, dirty_bit = 1, owned_bit = 2;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_e;
  state_e state;
  logic [lg_beats_lp-1:0] cnt;
  logic [lg_num_lce_lp-1:0] req_lce, tlce, n_tlce;
  logic [lg_lce_assoc_lp-1:0] rway, tway, n_rway, n_tway;
  logic wr, lru_dirty, lru_excl;
  logic rhit, rsh, cached, excl, owned, dirty;
  logic n_rhit, n_rsh, n_cached, n_excl, n_owned, n_dirty;
  int id;
  // The owned accumulator doubles as "transfer source already found", so the lowest-ID owner wins.
  always_comb begin
    id = 0;
    {n_rhit, n_rsh, n_cached, n_excl, n_owned, n_dirty} = {rhit, rsh, cached, excl, owned, dirty};
    {n_rway, n_tlce, n_tway} = {rway, tlce, tway};
    for (int j = 0; j < lce_per_beat_p; j++) begin
      id = int'(cnt) * lce_per_beat_p + j;
      if (id < num_lce_p) begin
        if (id == int'(req_lce)) begin
          n_rhit = beat_hits_i[j];
          n_rway = beat_ways_i[j];
          n_rsh = beat_coh_states_i[j][shared_bit];
        end else begin
          n_cached = n_cached | beat_hits_i[j];
          n_excl = n_excl | (beat_hits_i[j] & ~beat_coh_states_i[j][shared_bit]);
          n_dirty = n_dirty | (beat_hits_i[j] & beat_coh_states_i[j][dirty_bit]);
          if (beat_hits_i[j] & beat_coh_states_i[j][owned_bit] & ~n_owned) begin
            n_owned = 1'b1;
            n_tlce = lg_num_lce_lp'(id);
            n_tway = beat_ways_i[j];
          end
        end
      end
    end
  end
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      state <= IDLE;
      cnt <= '0;
      {req_lce, wr, lru_dirty, lru_excl} <= '0;
      {rhit, rsh, cached, excl, owned, dirty, rway, tlce, tway} <= '0;
    end else begin
      case (state)
        IDLE: if (gad_v_i) begin
          state <= ACCUM;
          cnt <= '0;
          {req_lce, wr, lru_dirty, lru_excl} <= {req_lce_i, req_type_flag_i, lru_dirty_flag_i, lru_cached_excl_flag_i};
          {rhit, rsh, cached, excl, owned, dirty, rway, tlce, tway} <= '0;
        end
        ACCUM: if (beat_v_i) begin
          {rhit, rsh, cached, excl, owned, dirty} <= {n_rhit, n_rsh, n_cached, n_excl, n_owned, n_dirty};
          {rway, tlce, tway} <= {n_rway, n_tlce, n_tway};
          if (cnt == lg_beats_lp'(num_beats_lp - 1)) state <= DONE;
          else cnt <= cnt + 1'b1;
        end
        default: if (yumi_i) state <= IDLE;
      endcase
    end
  logic done, upgrade;
  always_comb begin
    done = state == DONE;
    upgrade = wr & rhit & rsh;
    gad_ready_o = state == IDLE;
    v_o = done;
    transfer_flag_o = done & owned;
    upgrade_flag_o = done & upgrade;
    replacement_flag_o = done & ~upgrade & lru_excl & lru_dirty;
    req_addr_way_o = (done & rhit) ? rway : '0;
    transfer_lce_o = (done & owned) ? tlce : '0;
    transfer_way_o = (done & owned) ? tway : '0;
    invalidate_flag_o = done & ((moesi_p != 0) ? (wr & cached) : (wr ? cached : excl));
    downgrade_flag_o = done & ~wr & excl;
    cached_flag_o = done & cached;
    cached_exclusive_flag_o = done & excl;
    cached_owned_flag_o = done & owned;
    cached_dirty_flag_o = done & dirty;
  end
endmodule

// File: doc/bp_cce_gad_seq.md
BP_CCE_GAD_SEQ -- requirements
Module: bp_cce_gad_seq

Interface
REQ-001 The block SHALL have parameter num_lce_p, default 8: number of LCEs tracked by the directory.
REQ-002 The block SHALL have parameter lce_assoc_p, default 8: LCE associativity; way width lg_lce_assoc_lp = BSG_SAFE_CLOG2(lce_assoc_p).
REQ-003 The block SHALL have parameter lce_per_beat_p, default 2: directory entries delivered per read beat; num_beats_lp = ceil(num_lce_p/lce_per_beat_p).
REQ-004 The block SHALL have parameter moesi_p, default 0: 0 = MESI invalidate policy, 1 = MOESI owned-state policy.
REQ-005 The block SHALL have ports, one per line:
- clk_i  in  1  sole clock
- reset_n_i  in  1  asynchronous, active-low reset
- gad_v_i  in  1  start request
- gad_ready_o  out  1  accepts start
- req_lce_i  in  lg_num_lce_lp  requesting LCE
- req_type_flag_i  in  1  e_lce_req_type_wr = write
- lru_dirty_flag_i, lru_cached_excl_flag_i  in  1 each  LRU way status
- beat_v_i  in  1  directory beat valid, always accepted in ACCUM
- beat_hits_i  in  lce_per_beat_p  hit per entry
- beat_ways_i  in  lce_per_beat_p x lg_lce_assoc_lp  way per entry
- beat_coh_states_i  in  lce_per_beat_p x bp_cce_coh_bits  state per entry
- v_o  out  1  result valid
- yumi_i  in  1  result consumed
- req_addr_way_o, transfer_lce_o, transfer_way_o  out  way/LCE widths
- transfer_flag_o, replacement_flag_o, upgrade_flag_o, invalidate_flag_o, downgrade_flag_o, cached_flag_o, cached_exclusive_flag_o, cached_owned_flag_o, cached_dirty_flag_o  out  1 each

Function
REQ-006 The FSM SHALL have states IDLE, ACCUM, DONE; gad_ready_o=1 only in IDLE.
REQ-007 IDLE with gad_v_i=1 SHALL register req_lce_i, req_type_flag_i and both lru flags, clear all accumulators and the beat counter, and go to ACCUM.
REQ-008 Beat k SHALL carry LCE IDs k*lce_per_beat_p+j; entries with ID >= num_lce_p SHALL be ignored.
REQ-009 Per accepted beat, cached/excl (hit & ~shared bit)/owned (hit & owned bit)/dirty (hit & dirty bit) accumulators SHALL OR in entries whose ID != registered requester.
REQ-010 The entry whose ID equals the requester SHALL register req hit, req way and req shared bit.
REQ-011 The first non-requester entry, in ascending LCE ID, with hit and owned bit SHALL register transfer LCE and way; later owners SHALL NOT overwrite.
REQ-012 On the beat with counter = num_beats_lp-1 the FSM SHALL go to DONE next cycle with outputs already reflecting that beat; the counter SHALL NOT wrap.
REQ-013 beat_v_i outside ACCUM SHALL be ignored.
REQ-014 DONE SHALL hold v_o=1 and all outputs stable until yumi_i=1, then return to IDLE; gad_v_i SHALL NOT be accepted in the same cycle as yumi_i.
REQ-015 Flags: transfer = owned; upgrade = wr & req hit & req shared; replacement = ~upgrade & lru_cached_excl & lru_dirty; req_addr_way_o = req hit ? req way : 0.
REQ-016 moesi_p=0: invalidate = rd ? cached_exclusive : cached; downgrade = rd & cached_exclusive.
REQ-017 moesi_p=1: invalidate = wr & cached; downgrade = rd & cached_exclusive.
REQ-018 transfer_lce_o and transfer_way_o SHALL be 0 when transfer_flag_o=0.
REQ-019 Outputs outside DONE SHALL be 0 except gad_ready_o.

Reset
REQ-020 reset_n_i low SHALL asynchronously force IDLE, counter 0, all accumulators and registers 0, v_o=0, gad_ready_o=1, from any state including mid-ACCUM.
REQ-021 Release SHALL be synchronous-safe: first accept at the earliest on the first rising edge after deassertion.

Verification (num_lce_p=4, lce_per_beat_p=2, lce_assoc_p=8)
REQ-022 Read by LCE0; beat0 none; beat1 LCE3 hit way5, M state -> v_o two cycles after start; transfer=1, transfer_lce=3, transfer_way=5, moesi_p=0 invalidate=1, moesi_p=1 invalidate=0, downgrade=1.
REQ-023 Write by LCE1, LCE1 hit way2, S; LCE2 hit S -> upgrade=1, req_addr_way=2, invalidate=1, replacement=0 even with both lru flags=1.
REQ-024 Owners LCE1 way4 and LCE2 way7, requester 0 -> transfer_lce=1, transfer_way=4.
REQ-025 Hold yumi_i=0 for 5 cycles with gad_v_i=1 and random beats -> outputs stable, gad_ready_o=0, no new capture.
REQ-026 Assert reset_n_i low after beat0 -> v_o=0 immediately; after release, new request accumulates with no stale beat0 data.
REQ-027 num_lce_p=3, lce_per_beat_p=2, beat1 entry ID3 asserted hit/M -> ignored, cached_flag=0 when no other hits.
